// File: rtl/operand_fwd_ctrl_pkg.sv
// Shared types for the operand forwarding controller: mux select codes,
// operand source codes and the in-flight destination slot record.
package operand_fwd_ctrl_pkg;

    localparam int FWD_REG_AW = 5;
    localparam int FWD_SEL_W  = 3;

    localparam logic [FWD_SEL_W-1:0] SEL_RF      = 3'd0;
    localparam logic [FWD_SEL_W-1:0] SEL_MEM_ALU = 3'd1;
    localparam logic [FWD_SEL_W-1:0] SEL_WB      = 3'd2;
    localparam logic [FWD_SEL_W-1:0] SEL_WB_HOLD = 3'd3;
    localparam logic [FWD_SEL_W-1:0] SEL_IMM     = 3'd4;
    localparam logic [FWD_SEL_W-1:0] SEL_PC      = 3'd5;
    localparam logic [FWD_SEL_W-1:0] SEL_ZERO    = 3'd6;

    localparam logic [1:0] OPA_REG  = 2'd0;
    localparam logic [1:0] OPA_PC   = 2'd1;
    localparam logic [1:0] OPA_ZERO = 2'd2;
    localparam logic [1:0] OPA_RSVD = 2'd3;

    localparam logic OPB_REG = 1'b0;
    localparam logic OPB_IMM = 1'b1;

    typedef struct packed {
        logic                  valid;
        logic [FWD_REG_AW-1:0] rd;
        logic                  we;
        logic                  is_load;
    } slot_t;

    // x0 never forwards, so a zero destination is never a match.
    function automatic logic slot_match(input slot_t s,
                                        input logic [FWD_REG_AW-1:0] rs,
                                        input logic use_rs);
        return s.valid & s.we & (s.rd != '0) & (s.rd == rs) & use_rs;
    endfunction

endpackage

// File: rtl/operand_fwd_ctrl_fwd_src_resolve.sv
// Per-operand select resolver; youngest in-flight producer wins.
// WB-slot result depends on FWD_WB_BYPASS_EN (regfile write-through).
module fwd_src_resolve
    import operand_fwd_ctrl_pkg::*;
(
    input  logic                  use_i,
    input  logic [FWD_REG_AW-1:0] rs_i,
    input  logic                  is_reg_i,
    input  logic [FWD_SEL_W-1:0]  fixed_sel_i,
    input  slot_t                 ex_slot_i,
    input  slot_t                 mem_slot_i,
    input  slot_t                 wb_slot_i,
    output logic [FWD_SEL_W-1:0]  sel_o,
    output logic                  ex_load_hit_o
);

`ifdef FWD_WB_BYPASS_EN
    localparam logic [FWD_SEL_W-1:0] WB_HIT_SEL = SEL_RF;
`else
    localparam logic [FWD_SEL_W-1:0] WB_HIT_SEL = SEL_WB_HOLD;
`endif

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    assign ex_hit  = slot_match(ex_slot_i, rs_i, use_i);
    assign mem_hit = slot_match(mem_slot_i, rs_i, use_i);
    assign wb_hit  = slot_match(wb_slot_i, rs_i, use_i);

    assign ex_load_hit_o = ex_hit & ex_slot_i.is_load;

    // A load hit in EX is handled by the stall, so it falls through here.
    always_comb begin
        sel_o = SEL_RF;
        if (!is_reg_i) begin
            sel_o = fixed_sel_i;
        end else if (ex_hit && !ex_slot_i.is_load) begin
            sel_o = SEL_MEM_ALU;
        end else if (mem_hit) begin
            sel_o = SEL_WB;
        end else if (wb_hit) begin
            sel_o = WB_HIT_SEL;
        end
    end

endmodule

// File: rtl/operand_fwd_ctrl.sv
// Forwarding/hazard controller driving the EX operand mux selects.
// Optional: FWD_WB_BYPASS_EN (WB-slot hits read the regfile instead).
module operand_fwd_ctrl
    import operand_fwd_ctrl_pkg::*;
#(
    parameter int REG_AW = FWD_REG_AW,
    parameter int SEL_W  = FWD_SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [1:0]        id_opa_src,
    input  logic              id_opb_src,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic              ex_flush,
    input  logic              mem_stall,
    output logic [SEL_W-1:0]  ex_sel_a,
    output logic [SEL_W-1:0]  ex_sel_b,
    output logic              stall_id
);

    slot_t ex_q, ex_d;
    slot_t mem_q, mem_d;
    slot_t wb_q, wb_d;

    logic [SEL_W-1:0] sel_a_q, sel_a_d;
    logic [SEL_W-1:0] sel_b_q, sel_b_d;

    logic [SEL_W-1:0] res_a;
    logic [SEL_W-1:0] res_b;
    logic             load_hit_a;
    logic             load_hit_b;

    logic             is_reg_a;
    logic [SEL_W-1:0] fixed_a;
    logic             is_reg_b;

    assign is_reg_a = (id_opa_src == OPA_REG) | (id_opa_src == OPA_RSVD);
    assign fixed_a  = (id_opa_src == OPA_PC) ? SEL_PC : SEL_ZERO;
    assign is_reg_b = (id_opb_src == OPB_REG);

    fwd_src_resolve u_res_a (
        .use_i         (id_use_rs1),
        .rs_i          (id_rs1),
        .is_reg_i      (is_reg_a),
        .fixed_sel_i   (fixed_a),
        .ex_slot_i     (ex_q),
        .mem_slot_i    (mem_q),
        .wb_slot_i     (wb_q),
        .sel_o         (res_a),
        .ex_load_hit_o (load_hit_a)
    );

    fwd_src_resolve u_res_b (
        .use_i         (id_use_rs2),
        .rs_i          (id_rs2),
        .is_reg_i      (is_reg_b),
        .fixed_sel_i   (SEL_IMM),
        .ex_slot_i     (ex_q),
        .mem_slot_i    (mem_q),
        .wb_slot_i     (wb_q),
        .sel_o         (res_b),
        .ex_load_hit_o (load_hit_b)
    );

    assign stall_id = id_valid & (load_hit_a | load_hit_b);

    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        sel_a_d = sel_a_q;
        sel_b_d = sel_b_q;
        if (!mem_stall) begin
            mem_d = ex_q;
            wb_d  = mem_q;
            // Flush and load-use both insert a bubble into EX.
            if (ex_flush || stall_id) begin
                ex_d    = '0;
                sel_a_d = SEL_RF;
                sel_b_d = SEL_RF;
            end else begin
                ex_d.valid   = id_valid;
                ex_d.rd      = id_rd;
                ex_d.we      = id_we;
                ex_d.is_load = id_is_load;
                sel_a_d      = id_valid ? res_a : SEL_RF;
                sel_b_d      = id_valid ? res_b : SEL_RF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            sel_a_q <= '0;
            sel_b_q <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign ex_sel_a = sel_a_q;
    assign ex_sel_b = sel_b_q;

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Directed bench for operand_fwd_ctrl with hand-computed selects.
module tb_operand_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2;
    logic [1:0] id_opa_src;
    logic       id_opb_src;
    logic       id_we, id_is_load;
    logic       ex_flush, mem_stall;
    logic [2:0] ex_sel_a, ex_sel_b;
    logic       stall_id;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FWD_WB_BYPASS_EN
    localparam logic [2:0] D3_SEL = 3'd0;
`else
    localparam logic [2:0] D3_SEL = 3'd3;
`endif

    operand_fwd_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_opa_src (id_opa_src),
        .id_opb_src (id_opb_src),
        .id_rd      (id_rd),
        .id_we      (id_we),
        .id_is_load (id_is_load),
        .ex_flush   (ex_flush),
        .mem_stall  (mem_stall),
        .ex_sel_a   (ex_sel_a),
        .ex_sel_b   (ex_sel_b),
        .stall_id   (stall_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_sel(input string tag, input int a, input int b);
        chk({tag, ".sel_a"}, int'(ex_sel_a), a);
        chk({tag, ".sel_b"}, int'(ex_sel_b), b);
    endtask

    // valid, rs1, use1, rs2, use2, opa, opb, rd, we, load
    task automatic ins(input logic v, input int r1, input logic u1,
                       input int r2, input logic u2, input int opa,
                       input logic opb, input int rd, input logic we,
                       input logic ld);
        id_valid   = v;
        id_rs1     = 5'(r1);
        id_use_rs1 = u1;
        id_rs2     = 5'(r2);
        id_use_rs2 = u2;
        id_opa_src = 2'(opa);
        id_opb_src = opb;
        id_rd      = 5'(rd);
        id_we      = we;
        id_is_load = ld;
        #1;
    endtask

    task automatic nop();
        ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1;
        ex_flush = 1'b0;
        mem_stall = 1'b0;
        nop();
        tick();
        tick();
        rst = 1'b0;
        chk_sel("reset", 0, 0);
        chk("reset.stall", int'(stall_id), 0);

        // add x5,x1,x2 ; sub x6,x5,x7
        ins(1, 1, 1, 2, 1, 0, 0, 5, 1, 0);
        tick();
        chk_sel("add_first", 0, 0);
        ins(1, 5, 1, 7, 1, 0, 0, 6, 1, 0);
        chk("b2b.stall", int'(stall_id), 0);
        tick();
        chk_sel("b2b", 1, 0);
        drain();
        chk_sel("drain1", 0, 0);

        // add x5 ; nop ; or x8,x5,x5
        ins(1, 1, 1, 2, 1, 0, 0, 5, 1, 0);
        tick();
        nop();
        tick();
        ins(1, 5, 1, 5, 1, 0, 0, 8, 1, 0);
        tick();
        chk_sel("dist2", 2, 2);
        drain();

        // lw x3,0(x2) ; add x4,x3,x1
        ins(1, 2, 1, 0, 0, 0, 1, 3, 1, 1);
        tick();
        ins(1, 3, 1, 1, 1, 0, 0, 4, 1, 0);
        chk("lu.stall", int'(stall_id), 1);
        tick();
        chk_sel("lu.bubble", 0, 0);
        chk("lu.stall_clr", int'(stall_id), 0);
        tick();
        chk_sel("lu.resolve", 2, 0);
        drain();

        // add x9 ; nop ; nop ; add x10,x9,x0
        ins(1, 1, 1, 2, 1, 0, 0, 9, 1, 0);
        tick();
        nop();
        tick();
        tick();
        ins(1, 9, 1, 0, 1, 0, 0, 10, 1, 0);
        tick();
        chk_sel("dist3", int'(D3_SEL), 0);
        drain();

        // addi x0,x0,imm ; add x1,x0,x0 ; auipc x2 ; lui x3
        ins(1, 0, 1, 0, 0, 0, 1, 0, 1, 0);
        tick();
        chk_sel("addi_x0", 0, 4);
        ins(1, 0, 1, 0, 1, 0, 0, 1, 1, 0);
        tick();
        chk_sel("x0_src", 0, 0);
        ins(1, 0, 0, 0, 0, 1, 1, 2, 1, 0);
        tick();
        chk_sel("auipc", 5, 4);
        ins(1, 0, 0, 0, 0, 2, 1, 3, 1, 0);
        tick();
        chk_sel("lui", 6, 4);
        drain();

        // lw x3 ; add x4,x3,x1 with flush ; sub x13,x4,x3
        ins(1, 2, 1, 0, 0, 0, 1, 3, 1, 1);
        tick();
        ins(1, 3, 1, 1, 1, 0, 0, 4, 1, 0);
        ex_flush = 1'b1;
        chk("flush.stall", int'(stall_id), 1);
        tick();
        ex_flush = 1'b0;
        chk_sel("flush", 0, 0);
        ins(1, 4, 1, 3, 1, 0, 0, 13, 1, 0);
        chk("flush.nostall", int'(stall_id), 0);
        tick();
        chk_sel("flush.ex_inv", 0, 2);
        drain();

        // add x2 ; lw x3,0(x2) ; add x4,x3,x1 under mem_stall
        ins(1, 1, 1, 1, 1, 0, 0, 2, 1, 0);
        tick();
        ins(1, 2, 1, 0, 0, 0, 1, 3, 1, 1);
        tick();
        chk_sel("lw_fwd", 1, 4);
        ins(1, 3, 1, 1, 1, 0, 0, 4, 1, 0);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_sel($sformatf("mstall%0d", i), 1, 4);
            chk($sformatf("mstall%0d.stall", i), int'(stall_id), 1);
        end

        // reset while frozen and stalled
        rst = 1'b1;
        tick();
        chk_sel("rst_mid", 0, 0);
        chk("rst_mid.stall", int'(stall_id), 0);
        rst = 1'b0;
        mem_stall = 1'b0;
        tick();
        chk_sel("post_rst", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
